// File: rtl/pd_link_config_sequencer.sv
// Sequences LTSSM rate/width/link changes onto the packet identifier at packet boundaries (drain -> gate -> apply -> settle).
// Latency: idle link applies 2 cycles after cfg_req; beats arriving while gated are dropped and flagged, never stalled.
module pd_link_config_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DRAIN_TIMEOUT = 255,
    parameter int RESET_GEN     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_req,
    input  logic [2:0]  cfg_gen,
    input  logic [4:0]  cfg_lanes,
    input  logic        cfg_linkup,
    output logic        cfg_ack,
    output logic        cfg_err,
    output logic        cfg_busy,
    input  logic        rx_valid,
    input  logic [63:0] pl_valid,
    input  logic [63:0] pl_tlpstart,
    input  logic [63:0] pl_tlpend,
    input  logic [63:0] pl_dlpstart,
    input  logic [63:0] pl_dlpend,
    output logic        valid_pd,
    output logic [2:0]  gen,
    output logic        linkup,
    output logic [4:0]  numberOfDetectedLanes,
    output logic        in_packet,
    output logic        drain_timeout,
    output logic        beat_dropped
);

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_DRAIN  = 3'd1,
        S_APPLY  = 3'd2,
        S_SETTLE = 3'd3,
        S_REJECT = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(DRAIN_TIMEOUT - 1);
    localparam logic [7:0] SET_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  gen_q, gen_d;
    logic        linkup_q, linkup_d;
    logic [4:0]  lanes_q, lanes_d;
    logic [2:0]  lat_gen_q, lat_gen_d;
    logic        lat_linkup_q, lat_linkup_d;
    logic [4:0]  lat_lanes_q, lat_lanes_d;
    logic        in_packet_q, in_packet_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  set_cnt_q, set_cnt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        tmo_pulse_q, tmo_pulse_d;

    logic        gated;
    logic [63:0] marker;
    logic        in_pkt_next;

    assign gated  = (state_q == S_APPLY) || (state_q == S_SETTLE);
    assign marker = (pl_tlpstart | pl_tlpend | pl_dlpstart | pl_dlpend) & pl_valid;

    // Ascending scan so the highest marked byte decides; an end flag beats a start in the same byte.
    always_comb begin
        in_pkt_next = in_packet_q;
        if (valid_pd) begin
            for (int k = 0; k < 64; k++) begin
                if (marker[k]) begin
                    in_pkt_next = !(pl_tlpend[k] || pl_dlpend[k]);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gen_d        = gen_q;
        linkup_d     = linkup_q;
        lanes_d      = lanes_q;
        lat_gen_d    = lat_gen_q;
        lat_linkup_d = lat_linkup_q;
        lat_lanes_d  = lat_lanes_q;
        in_packet_d  = in_pkt_next;
        tmo_cnt_d    = tmo_cnt_q;
        set_cnt_d    = set_cnt_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        tmo_pulse_d  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (cfg_req && !ack_q) begin
                    lat_gen_d    = cfg_gen;
                    lat_linkup_d = cfg_linkup;
                    lat_lanes_d  = cfg_lanes;
                    if (cfg_gen == 3'd0 || cfg_gen > 3'd5) begin
                        state_d = S_REJECT;
                    end else if (!cfg_linkup) begin
                        // Link going down: no point waiting for the open packet to close.
                        state_d     = S_APPLY;
                        in_packet_d = 1'b0;
                    end else begin
                        state_d   = S_DRAIN;
                        tmo_cnt_d = 8'd0;
                    end
                end
            end
            S_DRAIN: begin
                if (!in_pkt_next) begin
                    state_d = S_APPLY;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = S_APPLY;
                    tmo_pulse_d = 1'b1;
                    in_packet_d = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_APPLY: begin
                gen_d     = lat_gen_q;
                linkup_d  = lat_linkup_q;
                lanes_d   = lat_lanes_q;
                set_cnt_d = 8'd0;
                state_d   = S_SETTLE;
            end
            S_SETTLE: begin
                if (set_cnt_q == SET_LAST) begin
                    state_d = S_RUN;
                    ack_d   = 1'b1;
                end else begin
                    set_cnt_d = set_cnt_q + 8'd1;
                end
            end
            S_REJECT: begin
                ack_d   = 1'b1;
                err_d   = 1'b1;
                state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RUN;
            gen_q        <= 3'(RESET_GEN);
            linkup_q     <= 1'b0;
            lanes_q      <= 5'd0;
            lat_gen_q    <= 3'(RESET_GEN);
            lat_linkup_q <= 1'b0;
            lat_lanes_q  <= 5'd0;
            in_packet_q  <= 1'b0;
            tmo_cnt_q    <= 8'd0;
            set_cnt_q    <= 8'd0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            tmo_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gen_q        <= gen_d;
            linkup_q     <= linkup_d;
            lanes_q      <= lanes_d;
            lat_gen_q    <= lat_gen_d;
            lat_linkup_q <= lat_linkup_d;
            lat_lanes_q  <= lat_lanes_d;
            in_packet_q  <= in_packet_d;
            tmo_cnt_q    <= tmo_cnt_d;
            set_cnt_q    <= set_cnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            tmo_pulse_q  <= tmo_pulse_d;
        end
    end

    assign valid_pd              = rx_valid && !gated;
    assign beat_dropped          = rx_valid && gated;
    assign cfg_busy              = (state_q != S_RUN);
    assign cfg_ack               = ack_q;
    assign cfg_err               = err_q;
    assign drain_timeout         = tmo_pulse_q;
    assign in_packet             = in_packet_q;
    assign gen                   = gen_q;
    assign linkup                = linkup_q;
    assign numberOfDetectedLanes = lanes_q;

endmodule

// File: tb/tb_pd_link_config_sequencer.sv
// Bench for pd_link_config_sequencer: random framing traffic against a descending-scan reference,
// plus request scenarios whose expected timelines are derived arithmetically from drain length.
module tb_pd_link_config_sequencer;

    localparam int SETTLE = 4;
    localparam int TMO    = 8;

    logic        clk;
    logic        reset_n;
    logic        cfg_req;
    logic [2:0]  cfg_gen;
    logic [4:0]  cfg_lanes;
    logic        cfg_linkup;
    logic        cfg_ack;
    logic        cfg_err;
    logic        cfg_busy;
    logic        rx_valid;
    logic [63:0] pl_valid;
    logic [63:0] pl_tlpstart;
    logic [63:0] pl_tlpend;
    logic [63:0] pl_dlpstart;
    logic [63:0] pl_dlpend;
    logic        valid_pd;
    logic [2:0]  gen;
    logic        linkup;
    logic [4:0]  numberOfDetectedLanes;
    logic        in_packet;
    logic        drain_timeout;
    logic        beat_dropped;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] cur_gen    = 3'd1;
    logic [4:0] cur_lanes  = 5'd0;
    logic       cur_linkup = 1'b0;

    pd_link_config_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .DRAIN_TIMEOUT (TMO),
        .RESET_GEN     (1)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .cfg_req               (cfg_req),
        .cfg_gen               (cfg_gen),
        .cfg_lanes             (cfg_lanes),
        .cfg_linkup            (cfg_linkup),
        .cfg_ack               (cfg_ack),
        .cfg_err               (cfg_err),
        .cfg_busy              (cfg_busy),
        .rx_valid              (rx_valid),
        .pl_valid              (pl_valid),
        .pl_tlpstart           (pl_tlpstart),
        .pl_tlpend             (pl_tlpend),
        .pl_dlpstart           (pl_dlpstart),
        .pl_dlpend             (pl_dlpend),
        .valid_pd              (valid_pd),
        .gen                   (gen),
        .linkup                (linkup),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .in_packet             (in_packet),
        .drain_timeout         (drain_timeout),
        .beat_dropped          (beat_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the highest marked valid byte decides; an end in that byte closes the packet.
    function automatic logic ref_next(input logic cur, input logic vld, input logic [63:0] v,
                                      input logic [63:0] ts, input logic [63:0] te,
                                      input logic [63:0] ds, input logic [63:0] de);
        if (!vld) return cur;
        for (int k = 63; k >= 0; k--) begin
            if (v[k] && (te[k] || de[k])) return 1'b0;
            if (v[k] && (ts[k] || ds[k])) return 1'b1;
        end
        return cur;
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
        rx_valid    = 1'b0;
        pl_valid    = '0;
        pl_tlpstart = '0;
        pl_tlpend   = '0;
        pl_dlpstart = '0;
        pl_dlpend   = '0;
    endtask

    // kind: 0 tlpstart, 1 tlpend, 2 dlpstart, 3 dlpend, 4 tlpstart+tlpend
    task automatic set_marker(input int b, input int kind);
        pl_valid[b] = 1'b1;
        case (kind)
            0: pl_tlpstart[b] = 1'b1;
            1: pl_tlpend[b]   = 1'b1;
            2: pl_dlpstart[b] = 1'b1;
            3: pl_dlpend[b]   = 1'b1;
            default: begin
                pl_tlpstart[b] = 1'b1;
                pl_tlpend[b]   = 1'b1;
            end
        endcase
    endtask

    task automatic test_reset;
        logic [15:0] obs, exp;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = {valid_pd, gen, linkup, numberOfDetectedLanes, in_packet, cfg_ack, cfg_err,
               cfg_busy, drain_timeout, beat_dropped};
        exp = {1'b0, 3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected %b", obs, exp);
        end
        next_cycle;
        reset_n = 1'b1;
        #1;
        n_tests++;
        if ({cfg_busy, gen, in_packet} !== {1'b0, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b gen=%0d pkt=%b", cfg_busy, gen, in_packet);
        end
    endtask

    task automatic test_framing;
        logic exp_pkt, nxt;
        int   nmk, b;
        exp_pkt = 1'b0;
        for (int i = 0; i < 60; i++) begin
            next_cycle;
            rx_valid = ($urandom_range(0, 3) != 0);
            nmk = $urandom_range(0, 3);
            for (int j = 0; j < nmk; j++) begin
                b = $urandom_range(0, 63);
                set_marker(b, $urandom_range(0, 4));
                pl_valid[b] = ($urandom_range(0, 3) != 0);
            end
            nxt = ref_next(exp_pkt, rx_valid, pl_valid, pl_tlpstart, pl_tlpend, pl_dlpstart, pl_dlpend);
            #1;
            n_tests++;
            if ({valid_pd, in_packet} !== {rx_valid, exp_pkt}) begin
                n_fail++;
                $display("FAIL framing beat %0d: got vpd=%b pkt=%b expected vpd=%b pkt=%b",
                         i, valid_pd, in_packet, rx_valid, exp_pkt);
            end
            exp_pkt = nxt;
        end
        next_cycle;
        rx_valid = 1'b1;
        set_marker(63, 0);
        set_marker(10, 3);
        #1;
        n_tests++;
        if (in_packet !== exp_pkt) begin
            n_fail++;
            $display("FAIL framing_last: got %b expected %b", in_packet, exp_pkt);
        end
        next_cycle;
        rx_valid = 1'b1;
        set_marker(20, 0);
        set_marker(63, 4);
        #1;
        n_tests++;
        if (in_packet !== 1'b1) begin
            n_fail++;
            $display("FAIL framing_highest_start: got %b expected 1", in_packet);
        end
        next_cycle;
        #1;
        n_tests++;
        if (in_packet !== 1'b0) begin
            n_fail++;
            $display("FAIL framing_same_byte_end_wins: got %b expected 0", in_packet);
        end
    endtask

    // mode 0: idle link; 1: packet opens with the request, closes after L plain beats;
    // 2: packet open before the request and closes in the request cycle.
    task automatic test_request(input int mode, input int L, input int sb, input int eb);
        int          A;
        logic [2:0]  g;
        logic [4:0]  ln;
        logic        gt, ep, late;
        logic [14:0] obs, exp;
        A  = (mode == 1) ? L + 2 : 2;
        g  = 3'($urandom_range(1, 5));
        ln = 5'($urandom_range(0, 31));
        if (mode == 2) begin
            next_cycle;
            rx_valid = 1'b1;
            set_marker(sb, 2);
        end
        for (int c = 0; c <= A + SETTLE + 3; c++) begin
            next_cycle;
            cfg_req  = (c <= A + SETTLE + 1);
            rx_valid = 1'($urandom_range(0, 1));
            if (c == 0) begin
                cfg_gen    = g;
                cfg_lanes  = ln;
                cfg_linkup = 1'b1;
            end else if (c == 1) begin
                cfg_gen    = 3'($urandom_range(0, 7));
                cfg_lanes  = 5'($urandom);
                cfg_linkup = 1'($urandom_range(0, 1));
            end
            if (mode == 1 && c == 0) begin rx_valid = 1'b1; set_marker(sb, 0); end
            if (mode == 1 && c == L + 1) begin rx_valid = 1'b1; set_marker(eb, 1); end
            if (mode == 2 && c == 0) begin rx_valid = 1'b1; set_marker(eb, 3); end
            #1;
            gt   = (c >= A) && (c <= A + SETTLE);
            ep   = ((mode == 1) && c >= 1 && c <= L + 1) || ((mode == 2) && c == 0);
            late = (c > A);
            obs = {cfg_busy, valid_pd, beat_dropped, cfg_ack, cfg_err, in_packet,
                   gen, numberOfDetectedLanes, linkup};
            exp = {(c >= 1 && c <= A + SETTLE), rx_valid && !gt, rx_valid && gt,
                   (c == A + SETTLE + 1), 1'b0, ep,
                   late ? g : cur_gen, late ? ln : cur_lanes, late ? 1'b1 : cur_linkup};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL request mode%0d L%0d cycle %0d: got %b expected %b", mode, L, c, obs, exp);
            end
        end
        cfg_req    = 1'b0;
        cur_gen    = g;
        cur_lanes  = ln;
        cur_linkup = 1'b1;
    endtask

    task automatic test_start_end;
        logic [2:0]  g;
        logic [4:0]  ln;
        logic [11:0] obs, exp;
        g  = 3'($urandom_range(1, 5));
        ln = 5'($urandom_range(0, 31));
        for (int c = 0; c <= 8; c++) begin
            next_cycle;
            cfg_req = (c <= 7);
            if (c == 0) begin
                cfg_gen = g; cfg_lanes = ln; cfg_linkup = 1'b1;
                rx_valid = 1'b1;
                set_marker(3, 1);
                set_marker(40, 2);
            end
            if (c == 1) begin
                rx_valid = 1'b1;
                set_marker(2, 3);
            end
            if (c >= 2) rx_valid = 1'b1;
            #1;
            obs = {in_packet, cfg_busy, valid_pd, cfg_ack, gen, numberOfDetectedLanes};
            exp = {(c == 1), (c >= 1 && c <= 6), !(c >= 2 && c <= 6), (c == 7),
                   (c >= 3) ? g : cur_gen, (c >= 3) ? ln : cur_lanes};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL start_end cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
        cfg_req   = 1'b0;
        cur_gen   = g;
        cur_lanes = ln;
    endtask

    task automatic test_timeout;
        logic [2:0]  g;
        logic [10:0] obs, exp;
        int          A;
        A = TMO + 1;
        g = 3'($urandom_range(1, 5));
        for (int c = 0; c <= A + SETTLE + 2; c++) begin
            next_cycle;
            cfg_req  = (c <= A + SETTLE + 1);
            rx_valid = 1'($urandom_range(0, 1));
            if (c == 0) begin
                cfg_gen = g; cfg_lanes = cur_lanes; cfg_linkup = 1'b1;
                rx_valid = 1'b1;
                set_marker($urandom_range(0, 63), 0);
            end
            #1;
            obs = {drain_timeout, in_packet, cfg_busy, cfg_ack, valid_pd, gen, cfg_err, beat_dropped, linkup};
            exp = {(c == A), (c >= 1 && c <= A - 1), (c >= 1 && c <= A + SETTLE), (c == A + SETTLE + 1),
                   rx_valid && !(c >= A && c <= A + SETTLE), (c > A) ? g : cur_gen, 1'b0,
                   rx_valid && (c >= A && c <= A + SETTLE), 1'b1};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
        cfg_req = 1'b0;
        cur_gen = g;
    endtask

    task automatic test_reject;
        logic [2:0] bad;
        logic [8:0] obs, exp;
        case ($urandom_range(0, 2))
            0:       bad = 3'd0;
            1:       bad = 3'd6;
            default: bad = 3'd7;
        endcase
        for (int c = 0; c <= 3; c++) begin
            next_cycle;
            cfg_req  = (c <= 2);
            rx_valid = 1'($urandom_range(0, 1));
            if (c == 0) begin
                cfg_gen = bad; cfg_lanes = ~cur_lanes; cfg_linkup = 1'b1;
            end
            #1;
            obs = {cfg_busy, cfg_ack, cfg_err, valid_pd, gen, numberOfDetectedLanes == cur_lanes};
            exp = {(c == 1), (c == 2), (c == 2), rx_valid, cur_gen, 1'b1};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reject gen%0d cycle %0d: got %b expected %b", bad, c, obs, exp);
            end
        end
        cfg_req = 1'b0;
    endtask

    task automatic test_linkdown;
        logic [2:0]  g;
        logic [4:0]  ln;
        logic [12:0] obs, exp;
        g  = 3'($urandom_range(1, 5));
        ln = 5'($urandom_range(0, 31));
        next_cycle;
        rx_valid = 1'b1;
        set_marker($urandom_range(0, 63), 2);
        for (int c = 0; c <= 7; c++) begin
            next_cycle;
            cfg_req  = (c <= 6);
            rx_valid = 1'($urandom_range(0, 1));
            if (c == 0) begin
                cfg_gen = g; cfg_lanes = ln; cfg_linkup = 1'b0;
            end
            #1;
            obs = {in_packet, cfg_busy, cfg_ack, valid_pd, linkup, gen, numberOfDetectedLanes};
            exp = {(c == 0), (c >= 1 && c <= 5), (c == 6), rx_valid && !(c >= 1 && c <= 5),
                   (c >= 2) ? 1'b0 : cur_linkup, (c >= 2) ? g : cur_gen, (c >= 2) ? ln : cur_lanes};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL linkdown cycle %0d: got %b expected %b", c, obs, exp);
            end
        end
        cfg_req    = 1'b0;
        cur_gen    = g;
        cur_lanes  = ln;
        cur_linkup = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [12:0] obs, exp;
        for (int c = 0; c <= 4; c++) begin
            next_cycle;
            cfg_req  = 1'b1;
            rx_valid = 1'b1;
            if (c == 0) begin
                cfg_gen = 3'd4; cfg_lanes = 5'd16; cfg_linkup = 1'b1;
            end
            #1;
            n_tests++;
            if ({beat_dropped, valid_pd} !== {(c >= 2), (c < 2)}) begin
                n_fail++;
                $display("FAIL settle_drop cycle %0d: got drop=%b vpd=%b", c, beat_dropped, valid_pd);
            end
        end
        reset_n = 1'b0;
        #1;
        obs = {cfg_busy, cfg_ack, cfg_err, in_packet, gen, linkup, numberOfDetectedLanes, beat_dropped};
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b expected %b", obs, exp);
        end
        cfg_req = 1'b0;
        next_cycle;
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            next_cycle;
            #1;
            n_tests++;
            if ({cfg_ack, cfg_busy, gen, linkup} !== {1'b0, 1'b0, 3'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_mid_no_ack cycle %0d: got ack=%b busy=%b gen=%0d", c, cfg_ack, cfg_busy, gen);
            end
        end
        cur_gen    = 3'd1;
        cur_lanes  = 5'd0;
        cur_linkup = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        cfg_req     = 1'b0;
        cfg_gen     = 3'd1;
        cfg_lanes   = 5'd0;
        cfg_linkup  = 1'b0;
        rx_valid    = 1'b0;
        pl_valid    = '0;
        pl_tlpstart = '0;
        pl_tlpend   = '0;
        pl_dlpstart = '0;
        pl_dlpend   = '0;

        test_reset;
        test_framing;
        test_request(0, 0, 0, 0);
        test_request(1, 3, 5, 12);
        for (int i = 0; i < 4; i++) begin
            test_request(1, $urandom_range(0, 5), $urandom_range(0, 63), $urandom_range(0, 63));
        end
        test_request(2, 0, $urandom_range(0, 63), $urandom_range(0, 63));
        test_request(0, 0, 0, 0);
        test_start_end;
        test_timeout;
        test_reject;
        test_linkdown;
        test_reset_mid;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
